// File: rtl/t_toggle_checker.sv
`default_nettype none
// ============================================================================
// Module   : t_toggle_checker
// Purpose  : Run-time checker for an edge-triggered T element. A reference
//            model q(n+1) = q(n) ^ t(n) is resynchronised on every sample, so
//            each observed mismatch is counted once and cannot cascade.
//            A run is: start -> SYNC (one edge, seeds the model) -> RUN
//            (run_len samples, or fewer if stop) -> DONE (results held).
// Ports    : clk, rst_n (async, active-low)
//            start, stop, run_len[CNT_W]          run control
//            t_in, q_in                           observed element
//            busy, done, pass                     status
//            err_cnt, toggle_cnt [CNT_W]          saturating counters
//            first_err_idx [CNT_W], err_seen      first mismatch location
// Revision : 1.0  initial release
// ============================================================================
module t_toggle_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] run_len,
    input  logic             t_in,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err_seen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len_lat;
    logic [CNT_W-1:0] idx;
    logic             exp_q;
    logic             prev_q;

    logic             accept_start;
    logic             mismatch;
    logic             run_last;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] toggle_cnt_nxt;

    // Model prediction for this edge versus what the element actually shows.
    assign mismatch = (q_in != exp_q);

    // Compare one bit wider so idx+1 cannot alias when run_len is all ones.
    assign run_last = (({1'b0, idx} + 1'b1) == {1'b0, len_lat}) || stop;

    assign err_cnt_nxt    = (mismatch && (err_cnt != CNT_MAX))
                          ? err_cnt + 1'b1 : err_cnt;
    assign toggle_cnt_nxt = ((q_in != prev_q) && (toggle_cnt != CNT_MAX))
                          ? toggle_cnt + 1'b1 : toggle_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        accept_start = 1'b0;
        case (state)
            ST_IDLE: begin
                // start takes priority over stop here: stop is only
                // meaningful in RUN.
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                busy      = 1'b1;
                state_nxt = (len_lat == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (run_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = ST_SYNC;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: model, counters and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lat       <= '0;
            idx           <= '0;
            exp_q         <= 1'b0;
            prev_q        <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            toggle_cnt    <= '0;
            first_err_idx <= '0;
            err_seen      <= 1'b0;
        end else begin
            if (accept_start) begin
                len_lat       <= run_len;
                pass          <= 1'b0;
                err_cnt       <= '0;
                toggle_cnt    <= '0;
                first_err_idx <= '0;
                err_seen      <= 1'b0;
            end

            if (state == ST_SYNC) begin
                exp_q  <= q_in ^ t_in;
                prev_q <= q_in;
                idx    <= '0;
                // Empty run: nothing observed, so the result is a pass.
                if (len_lat == '0) begin
                    pass <= (err_cnt == '0);
                end
            end

            if (state == ST_RUN) begin
                err_cnt    <= err_cnt_nxt;
                toggle_cnt <= toggle_cnt_nxt;
                if (mismatch && !err_seen) begin
                    first_err_idx <= idx;
                    err_seen      <= 1'b1;
                end
                // Always reseed from the observed output so a single fault
                // is reported once (plus its return edge), not forever.
                exp_q  <= q_in ^ t_in;
                prev_q <= q_in;
                idx    <= idx + 1'b1;
                // Use the count including this final sample.
                if (run_last) begin
                    pass <= (err_cnt_nxt == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t_toggle_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_t_toggle_checker
// Purpose  : Self-checking bench for t_toggle_checker. Two instances share
//            the stimulus: CNT_W=8 (main) and CNT_W=3 (narrow counters).
//            Expected results come from sample arrays evaluated directly
//            against the T-element rule q(n+1) = q(n) ^ t(n).
// Revision : 1.0  initial release
// ============================================================================
module tb_t_toggle_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       t_in = 1'b0;
    logic       q_in = 1'b0;
    logic [7:0] run_len = '0;

    logic       busy8, done8, pass8, seen8;
    logic [7:0] err8, tog8, fidx8;
    logic       busy3, done3, pass3, seen3;
    logic [2:0] err3, tog3, fidx3;

    int vectors = 0;
    int miscompares = 0;

    // Index 0 is the SYNC sample, 1..n are RUN samples 0..n-1.
    logic ta [0:300];
    logic qa [0:300];

    t_toggle_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .run_len(run_len), .t_in(t_in), .q_in(q_in),
        .busy(busy8), .done(done8), .pass(pass8), .err_cnt(err8),
        .toggle_cnt(tog8), .first_err_idx(fidx8), .err_seen(seen8)
    );

    t_toggle_checker #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .run_len(run_len[2:0]), .t_in(t_in), .q_in(q_in),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .toggle_cnt(tog3), .first_err_idx(fidx3), .err_seen(seen3)
    );

    always #5 clk = ~clk;

    // Fill arrays with a correct T element, optionally flipping one RUN index.
    task automatic fill_model(input int n, input int t_mode, input int flip_idx);
        logic qc;
        qc = 1'b0;
        for (int k = 0; k <= n; k++) begin
            ta[k] = (t_mode == 1) ? 1'b1 : 1'($urandom % 2);
            qa[k] = qc ^ ((k - 1 == flip_idx) ? 1'b1 : 1'b0);
            qc    = qc ^ ta[k];
        end
    endtask

    // Drive one complete run and compare the held results with the model.
    task automatic do_run(input string name, input int len, input int stop_at,
                          input bit which, input bit poke_start);
        int nsamp, errs, tog, first, maxv;
        int o_err, o_tog, o_fidx;
        logic o_busy, o_done, o_pass, o_seen;

        nsamp = (len == 0) ? 0 :
                ((stop_at >= 0 && stop_at < len - 1) ? stop_at + 1 : len);
        errs = 0; tog = 0; first = -1;
        for (int k = 1; k <= nsamp; k++) begin
            if (qa[k] != (qa[k-1] ^ ta[k-1])) begin
                errs++;
                if (first < 0) first = k - 1;
            end
            if (qa[k] != qa[k-1]) tog++;
        end
        maxv = which ? 7 : 255;

        @(negedge clk);
        start   = 1'b1;
        stop    = 1'($urandom % 2);
        run_len = 8'(len);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= nsamp; k++) begin
            t_in = ta[k];
            q_in = qa[k];
            stop = (k >= 1 && k - 1 == stop_at) ? 1'b1 :
                   ((k == 0) ? 1'($urandom % 2) : 1'b0);
            if (poke_start && k == 2) begin
                start   = 1'b1;
                run_len = 8'(len + 3);
            end
            o_busy = which ? busy3 : busy8;
            vectors++;
            if (o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy@%0d: got %b want 1", name, k, o_busy);
            end
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
        end

        o_busy = which ? busy3 : busy8;
        o_done = which ? done3 : done8;
        o_pass = which ? pass3 : pass8;
        o_seen = which ? seen3 : seen8;
        o_err  = which ? int'(err3)  : int'(err8);
        o_tog  = which ? int'(tog3)  : int'(tog8);
        o_fidx = which ? int'(fidx3) : int'(fidx8);

        vectors += 7;
        if (o_done !== 1'b1) begin
            miscompares++; $display("FAIL %s done: got %b want 1", name, o_done);
        end
        if (o_busy !== 1'b0) begin
            miscompares++; $display("FAIL %s busy_end: got %b want 0", name, o_busy);
        end
        if (o_pass !== (errs == 0)) begin
            miscompares++; $display("FAIL %s pass: got %b want %0d", name, o_pass, errs == 0);
        end
        if (o_err != ((errs > maxv) ? maxv : errs)) begin
            miscompares++; $display("FAIL %s err_cnt: got %0d want %0d", name, o_err, errs);
        end
        if (o_tog != ((tog > maxv) ? maxv : tog)) begin
            miscompares++; $display("FAIL %s toggle_cnt: got %0d want %0d", name, o_tog, tog);
        end
        if (o_seen !== (errs > 0)) begin
            miscompares++; $display("FAIL %s err_seen: got %b want %0d", name, o_seen, errs > 0);
        end
        if (o_fidx != ((first < 0) ? 0 : first)) begin
            miscompares++; $display("FAIL %s first_err_idx: got %0d want %0d", name, o_fidx, first);
        end

        // Results must hold in DONE.
        @(negedge clk);
        o_done = which ? done3 : done8;
        o_err  = which ? int'(err3) : int'(err8);
        vectors += 2;
        if (o_done !== 1'b1) begin
            miscompares++; $display("FAIL %s done_hold: got %b want 1", name, o_done);
        end
        if (o_err != ((errs > maxv) ? maxv : errs)) begin
            miscompares++; $display("FAIL %s err_hold: got %0d want %0d", name, o_err, errs);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy8, done8, pass8, seen8, err8, tog8, fidx8} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got %h want 0",
                     {busy8, done8, pass8, seen8, err8, tog8, fidx8});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset idle: got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        fill_model(4, 1, -1);
        do_run("basic", 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_stuck();
        for (int k = 0; k <= 4; k++) begin ta[k] = 1'b1; qa[k] = 1'b0; end
        do_run("stuck", 4, -1, 1'b0, 1'b0);
    endtask

    task automatic test_flip();
        logic [8:0] tseq;
        logic qc;
        tseq = 9'b011010110;          // bit k = t of sample k (0,1,1,0,1,0,1,1,0)
        qc = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            ta[k] = tseq[k];
            qa[k] = qc ^ ((k == 4) ? 1'b1 : 1'b0);
            qc    = qc ^ ta[k];
        end
        do_run("flip", 8, -1, 1'b0, 1'b0);
        vectors += 2;
        if (err8 !== 8'd2) begin
            miscompares++; $display("FAIL flip err_cnt_abs: got %0d want 2", err8);
        end
        if (fidx8 !== 8'd3) begin
            miscompares++; $display("FAIL flip first_abs: got %0d want 3", fidx8);
        end
    endtask

    task automatic test_stop_and_zero();
        fill_model(8, 0, 5);
        do_run("stop", 8, 2, 1'b0, 1'b1);
        fill_model(0, 0, -1);
        do_run("zero_len", 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_narrow_and_abort();
        for (int k = 0; k <= 7; k++) begin ta[k] = 1'b1; qa[k] = 1'b0; end
        do_run("narrow", 7, -1, 1'b1, 1'b0);
        // Rerun from DONE, then abort with reset at RUN idx 2.
        @(negedge clk);
        start = 1'b1; run_len = 8'd7;
        @(negedge clk);
        start = 1'b0; t_in = 1'b1; q_in = 1'b0;    // SYNC
        repeat (2) @(negedge clk);                 // RUN idx 0, 1
        @(negedge clk);                            // RUN idx 2
        vectors++;
        if (busy3 !== 1'b1) begin
            miscompares++; $display("FAIL abort pre_busy: got %b want 1", busy3);
        end
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if ({busy3, done3, pass3, seen3, err3, tog3, fidx3} !== '0) begin
            miscompares++;
            $display("FAIL abort async3: got %h want 0",
                     {busy3, done3, pass3, seen3, err3, tog3, fidx3});
        end
        if ({busy8, done8, pass8, seen8, err8, tog8, fidx8} !== '0) begin
            miscompares++;
            $display("FAIL abort async8: got %h want 0",
                     {busy8, done8, pass8, seen8, err8, tog8, fidx8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy3 !== 1'b0 || done3 !== 1'b0) begin
                miscompares++;
                $display("FAIL abort idle: got busy=%b done=%b want 0 0", busy3, done3);
            end
        end
    endtask

    task automatic test_random();
        int len, stop_at;
        logic qc;
        for (int r = 0; r < 25; r++) begin
            len     = $urandom_range(0, 20);
            stop_at = ($urandom % 3 == 0) ? int'($urandom_range(0, 20)) : -1;
            qc = 1'($urandom % 2);
            for (int k = 0; k <= len; k++) begin
                ta[k] = 1'($urandom % 2);
                qa[k] = qc ^ (($urandom % 6 == 0) ? 1'b1 : 1'b0);
                qc    = qa[k] ^ ta[k];
            end
            do_run("random", len, stop_at, 1'b0, 1'($urandom % 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_flip();
        test_stop_and_zero();
        test_narrow_and_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t_toggle_checker.md
T_TOGGLE_CHECKER -- requirements
Module: t_toggle_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of the run-length and all counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a checking run.
REQ-005 stop  input  1  early end of the current run.
REQ-006 run_len  input  CNT_W  number of RUN samples; sampled on the accepted start.
REQ-007 t_in  input  1  toggle input being applied to the observed T element.
REQ-008 q_in  input  1  output of the observed T element.
REQ-009 busy  output  1  high in SYNC and RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  run finished with zero mismatches; valid while done=1.
REQ-012 err_cnt  output  CNT_W  mismatch count, saturating.
REQ-013 toggle_cnt  output  CNT_W  observed q_in transitions, saturating.
REQ-014 first_err_idx  output  CNT_W  RUN sample index of the first mismatch.
REQ-015 err_seen  output  1  first_err_idx is valid.

Function
REQ-016 Reference model: edge-triggered T element, q(n+1) = q(n) XOR t(n), with t_in and q_in sampled at the same rising edge.
REQ-017 The FSM shall have exactly the states IDLE, SYNC, RUN and DONE.
REQ-018 IDLE: when start=1 at an edge, the block shall latch run_len, clear err_cnt, toggle_cnt, err_seen and first_err_idx, and go to SYNC.
REQ-019 SYNC: one edge only; the block shall set exp <= q_in XOR t_in, prev_q <= q_in and idx <= 0, then go to RUN (or to DONE if the latched run_len=0).
REQ-020 RUN, at each edge:
- mismatch when q_in != exp;
- on mismatch: err_cnt += 1; if err_seen=0, set first_err_idx <= idx and err_seen <= 1;
- next exp <= q_in XOR t_in in all cases, so a mismatch resyncs the model and one fault cannot cascade;
- toggle_cnt += 1 when q_in != prev_q; then prev_q <= q_in;
- idx += 1.
REQ-021 RUN exit: go to DONE at the edge where idx+1 == latched run_len, or where stop=1; the sample taken at that edge shall still be counted.
REQ-022 DONE: pass shall be registered as (err_cnt==0), using the final count including the last sample; counters shall hold; start=1 shall behave exactly as in IDLE (REQ-018).
REQ-023 start while busy=1 shall be ignored; stop outside RUN shall be ignored; when start and stop are both 1 in IDLE, start wins.
REQ-024 err_cnt and toggle_cnt shall saturate at 2^CNT_W-1 and never wrap; idx shall not wrap within a run, since run_len is at most 2^CNT_W-1.
REQ-025 Latency: busy rises 1 cycle after the start edge; done rises 1 cycle after the final RUN edge.

Reset
REQ-026 While rst_n=0, independent of clk, the block shall hold: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, toggle_cnt=0, first_err_idx=0, err_seen=0, exp=0, prev_q=0, idx=0.
REQ-027 Reset asserted mid-run shall abort the run immediately; after release the block shall stay in IDLE until a new start.

Verification
REQ-028 Correct model, t_in=1 constant, run_len=4 -> busy for 5 cycles, done=1, pass=1, err_cnt=0, toggle_cnt=4, err_seen=0.
REQ-029 q_in stuck at 0, t_in=1, run_len=4 -> err_cnt=4, first_err_idx=0, err_seen=1, toggle_cnt=0, pass=0.
REQ-030 Correct model, t sequence 0,1,1,0,1,0,1,1,0, single q_in flip injected at RUN idx 3 only, run_len=8 -> err_cnt=2 (the flip and its return), first_err_idx=3, pass=0.
REQ-031 run_len=8, stop pulsed at RUN idx 2 -> done after 3 samples; start pulsed during RUN is ignored; run_len=0 -> SYNC then DONE with pass=1, err_cnt=0.
REQ-032 CNT_W=3, q_in stuck at 0, t_in=1, run_len=7, then rerun -> err_cnt saturates at 7; rst_n pulsed low at RUN idx 2 of the rerun -> all outputs 0 asynchronously; IDLE held until the next start.
